// File: rtl/uart_pkg.sv
// Shared UART definitions: default link rate, derived baud constants used by
// both the transmitter and the receiver, and the receiver state encoding.
package uart_pkg;

    localparam int DEF_CLK_FREQ  = 50_000_000;
    localparam int DEF_BAUD_RATE = 19_200;

    // Clocks per bit for a given system clock and line rate.
    function automatic int calc_baud_cnt(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // One definition of the bit timing for both ends of the link.
    localparam int BAUD_CNT = calc_baud_cnt(DEF_CLK_FREQ, DEF_BAUD_RATE);
    localparam int HALF_CNT = BAUD_CNT / 2;

    // Counter widths and frame length (8 data bits + stop bit after the start).
    localparam int CNT_W      = 12;
    localparam int BIT_W      = 4;
    localparam int FRAME_BITS = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RECV  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line plus a falling-edge
// detector on the synchronised value. All flops reset to the idle-high level
// so that reset release never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);

    logic meta;
    logic sync_d;

    // Resynchronise the line and keep the previous synchronised value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b1;
            sync_out <= 1'b1;
            sync_d   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make the three flops shift one
            // stage per clock; blocking would collapse them into one wire.
            meta     <= async_in;
            sync_out <= meta;
            sync_d   <= sync_out;
        end
    end

    // Falling edge: line was high last cycle and is low now.
    assign fall = sync_d & ~sync_out;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, fixed baud rate. The start bit is validated at
// mid-bit, each following bit is sampled at its centre, and the completed byte
// is presented on a rdy/clr_rdy handshake with overrun status.
// Optional feature macro: UART_RX_FRAME_CHK_EN adds the frm_err output that
// flags a low stop bit; without it the stop bit is sampled but ignored.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEF_CLK_FREQ,
    parameter int BAUD_RATE = DEF_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
`ifdef UART_RX_FRAME_CHK_EN
    output logic       frm_err,
`endif
    output logic       overrun
);

    localparam int BIT_TICKS  = calc_baud_cnt(CLK_FREQ, BAUD_RATE);
    localparam int HALF_TICKS = BIT_TICKS / 2;

    // The counter starts at 0 on entry/sample, so the terminal value is one
    // less than the interval length to sample exactly every BIT_TICKS clocks.
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);
    localparam logic [BIT_W-1:0] BITS_DONE = BIT_W'(FRAME_BITS);

    rx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [8:0]       shreg;
    logic             rx_sync;
    logic             fall;
    logic             sample;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (RX),
        .sync_out (rx_sync),
        .fall     (fall)
    );

    // Sample strobe: half a bit into START, one full bit in RECV.
    always_comb begin
        // NOTE: default first so every path assigns sample and no latch forms.
        sample = 1'b0;
        case (state)
            START:   sample = (baud_cnt == HALF_LAST);
            RECV:    sample = (baud_cnt == BIT_LAST);
            default: sample = 1'b0;
        endcase
    end

`ifndef UART_RX_FRAME_CHK_EN
    // Stop bit is still shifted in to keep frame timing, but nothing reads it.
    logic unused_stop;
    assign unused_stop = shreg[8];
`endif

    // Receiver FSM with counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rdy      <= 1'b0;
            overrun  <= 1'b0;
`ifdef UART_RX_FRAME_CHK_EN
            frm_err  <= 1'b0;
`endif
        end else begin
            // Consumer acknowledge; a done in the same cycle overrides below.
            if (clr_rdy) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (fall) begin
                        state   <= START;
                        bit_cnt <= '0;
                    end
                end

                START: begin
                    if (sample) begin
                        baud_cnt <= '0;
                        // Line still low at mid-bit: genuine start bit.
                        state    <= rx_sync ? IDLE : RECV;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                RECV: begin
                    if (bit_cnt == BITS_DONE) begin
                        // Byte complete: shreg[7:0] is data, shreg[8] is stop.
                        state    <= IDLE;
                        baud_cnt <= '0;
                        rx_data  <= shreg[7:0];
                        rdy      <= 1'b1;
                        overrun  <= rdy & ~clr_rdy;
`ifdef UART_RX_FRAME_CHK_EN
                        frm_err  <= ~shreg[8];
`endif
                    end else if (sample) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        shreg    <= {rx_sync, shreg[8:1]};
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule
